mem_stage_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle memory stage. It sits between the execute stage and the data memory. It selects GP or FP store data and aligns stores into byte lanes with byte enables. It extracts and sign/zero-extends load data, runs a req/ack transaction with a stall back to the processor, and flags misaligned or timed-out accesses.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 76 +++++++
 rtl/mem_stage_pipe.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the handshaked memory stage.
//   state_t    : stage FSM encoding
//   size_t     : access size encoding
//   lane_off_w : number of address bits that select a byte lane
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_FULL = 2'd2
  } size_t;

  // Lane-offset width: log2 of the number of byte lanes in the data bus.
  function automatic int unsigned lane_off_w(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for the memory stage.
//   size       : access size
//   lane       : addressed byte lane (lane 0 = bits [0:7], big-endian)
//   sext       : sign-extend a sub-word load
//   store_data : store data, right-justified in the low lanes
//   load_raw   : raw data returned by memory
//   store_rep  : store data replicated across all lanes
//   byte_en    : lane enables (bit k = lane k)
//   misalign   : size/lane combination is not naturally aligned
//   load_ext   : addressed lane(s) right-justified and extended
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned OB = lane_off_w(DATA_WIDTH),
  localparam int unsigned NL = DATA_WIDTH / 8
) (
  input  size_t                 size,
  input  logic [OB-1:0]         lane,
  input  logic                  sext,
  input  logic [0:DATA_WIDTH-1] store_data,
  input  logic [0:DATA_WIDTH-1] load_raw,
  output logic [0:DATA_WIDTH-1] store_rep,
  output logic [0:NL-1]         byte_en,
  output logic                  misalign,
  output logic [0:DATA_WIDTH-1] load_ext
);

  logic [OB-1:0] half_lo;
  logic [OB-1:0] half_hi;
  logic [0:7]    lane_byte;
  logic [0:15]   lane_half;

  // Size-dependent replication, enables, alignment check and load extraction.
  always_comb begin
    store_rep = '0;
    byte_en   = '0;
    misalign  = 1'b0;
    load_ext  = '0;
    half_lo   = {lane[OB-1:1], 1'b0};
    half_hi   = {lane[OB-1:1], 1'b1};
    lane_byte = load_raw[8*int'(lane) +: 8];
    lane_half = load_raw[8*int'(half_lo) +: 16];
    case (size)
      SZ_BYTE: begin
        for (int k = 0; k < int'(NL); k++) begin
          store_rep[8*k +: 8] = store_data[DATA_WIDTH-8 +: 8];
        end
        byte_en[lane] = 1'b1;
        load_ext = {DATA_WIDTH{sext & lane_byte[0]}};
        load_ext[DATA_WIDTH-8 +: 8] = lane_byte;
      end
      SZ_HALF: begin
        // Even lanes take the upper byte of the half, odd lanes the lower.
        for (int k = 0; k < int'(NL); k++) begin
          store_rep[8*k +: 8] = store_data[DATA_WIDTH-16+8*(k%2) +: 8];
        end
        byte_en[half_lo] = 1'b1;
        byte_en[half_hi] = 1'b1;
        misalign = lane[0];
        load_ext = {DATA_WIDTH{sext & lane_half[0]}};
        load_ext[DATA_WIDTH-16 +: 16] = lane_half;
      end
      SZ_FULL: begin
        store_rep = store_data;
        byte_en   = '1;
        misalign  = (lane != '0);
        load_ext  = load_raw;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// Handshaked memory stage between execute and data memory.
//   Processor side: valid/store_fp/addr/gp+fp data/write_enable/size/sign in,
//                   stall (combinational), data, data_valid, error out.
//   Memory side:    req/addr/data/byte_en/write_enable out, ack/data in.
// Requests are latched in IDLE, held in REQ until ack or timeout, and
// reported with a one-cycle data_valid pulse in DONE.
module mem_stage_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid_from_proc,
  input  logic                    store_fp,
  input  logic [0:ADDR_WIDTH-1]   addr_from_proc,
  input  logic [0:DATA_WIDTH-1]   gp_data_from_proc,
  input  logic [0:DATA_WIDTH-1]   fp_data_from_proc,
  input  logic                    write_enable_from_proc,
  input  logic                    byte_from_proc,
  input  logic                    half_word_from_proc,
  input  logic                    sign_extend_from_proc,
  output logic                    stall_to_proc,
  output logic [0:DATA_WIDTH-1]   data_to_proc,
  output logic                    data_valid_to_proc,
  output logic                    error_to_proc,
  output logic                    req_to_mem,
  output logic [0:ADDR_WIDTH-1]   addr_to_mem,
  output logic [0:DATA_WIDTH-1]   data_to_mem,
  output logic [0:DATA_WIDTH/8-1] byte_en_to_mem,
  output logic                    write_enable_to_mem,
  input  logic                    ack_from_mem,
  input  logic [0:DATA_WIDTH-1]   data_from_mem
);

  localparam int unsigned OB = lane_off_w(DATA_WIDTH);
  localparam int unsigned NL = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t                 state_q, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_nxt;
  logic [OB-1:0]          lane_q, lane_nxt;
  size_t                  size_q, size_nxt;
  logic                   sext_q, sext_nxt;

  logic                   req_nxt;
  logic [0:ADDR_WIDTH-1]  addr_nxt;
  logic [0:DATA_WIDTH-1]  dmem_nxt;
  logic [0:NL-1]          be_nxt;
  logic                   we_nxt;
  logic [0:DATA_WIDTH-1]  dproc_nxt;
  logic                   dv_nxt;
  logic                   err_nxt;

  size_t                  size_in;
  logic [OB-1:0]          lane_in;
  size_t                  al_size;
  logic [OB-1:0]          al_lane;
  logic                   al_sext;
  logic [0:DATA_WIDTH-1]  store_sel;
  logic [0:DATA_WIDTH-1]  store_rep;
  logic [0:NL-1]          byte_en;
  logic                   misalign;
  logic [0:DATA_WIDTH-1]  load_ext;

  // Decode the incoming request; byte wins over half.
  always_comb begin
    size_in   = byte_from_proc      ? SZ_BYTE :
                half_word_from_proc ? SZ_HALF : SZ_FULL;
    lane_in   = addr_from_proc[ADDR_WIDTH-OB +: OB];
    store_sel = store_fp ? fp_data_from_proc : gp_data_from_proc;
    // In REQ the aligner works on the latched request for load extraction.
    al_size   = (state_q == REQ) ? size_q : size_in;
    al_lane   = (state_q == REQ) ? lane_q : lane_in;
    al_sext   = (state_q == REQ) ? sext_q : sign_extend_from_proc;
  end

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size       (al_size),
    .lane       (al_lane),
    .sext       (al_sext),
    .store_data (store_sel),
    .load_raw   (data_from_mem),
    .store_rep  (store_rep),
    .byte_en    (byte_en),
    .misalign   (misalign),
    .load_ext   (load_ext)
  );

  assign stall_to_proc = ((state_q == IDLE) && valid_from_proc) || (state_q == REQ);

  // Next state and next registered outputs.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    lane_nxt  = lane_q;
    size_nxt  = size_q;
    sext_nxt  = sext_q;
    req_nxt   = req_to_mem;
    addr_nxt  = addr_to_mem;
    dmem_nxt  = data_to_mem;
    be_nxt    = byte_en_to_mem;
    we_nxt    = write_enable_to_mem;
    dproc_nxt = data_to_proc;
    dv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_from_proc) begin
          if (misalign) begin
            state_nxt = DONE;
            dv_nxt    = 1'b1;
            err_nxt   = 1'b1;
            dproc_nxt = '0;
          end else begin
            state_nxt = REQ;
            cnt_nxt   = '0;
            req_nxt   = 1'b1;
            addr_nxt  = addr_from_proc;
            addr_nxt[ADDR_WIDTH-OB +: OB] = '0;
            dmem_nxt  = store_rep;
            be_nxt    = byte_en;
            we_nxt    = write_enable_from_proc;
            lane_nxt  = lane_in;
            size_nxt  = size_in;
            sext_nxt  = sign_extend_from_proc;
          end
        end
      end
      REQ: begin
        if (ack_from_mem) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          dv_nxt    = 1'b1;
          dproc_nxt = write_enable_to_mem ? '0 : load_ext;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          dv_nxt    = 1'b1;
          err_nxt   = 1'b1;
          dproc_nxt = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      lane_q              <= '0;
      size_q              <= SZ_BYTE;
      sext_q              <= 1'b0;
      req_to_mem          <= 1'b0;
      addr_to_mem         <= '0;
      data_to_mem         <= '0;
      byte_en_to_mem      <= '0;
      write_enable_to_mem <= 1'b0;
      data_to_proc        <= '0;
      data_valid_to_proc  <= 1'b0;
      error_to_proc       <= 1'b0;
    end else begin
      state_q             <= state_nxt;
      cnt_q               <= cnt_nxt;
      lane_q              <= lane_nxt;
      size_q              <= size_nxt;
      sext_q              <= sext_nxt;
      req_to_mem          <= req_nxt;
      addr_to_mem         <= addr_nxt;
      data_to_mem         <= dmem_nxt;
      byte_en_to_mem      <= be_nxt;
      write_enable_to_mem <= we_nxt;
      data_to_proc        <= dproc_nxt;
      data_valid_to_proc  <= dv_nxt;
      error_to_proc       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed scoreboard bench for mem_stage_pipe (32-bit data, TIMEOUT=15).
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_from_proc;
  logic        store_fp;
  logic [0:31] addr_from_proc;
  logic [0:31] gp_data_from_proc;
  logic [0:31] fp_data_from_proc;
  logic        write_enable_from_proc;
  logic        byte_from_proc;
  logic        half_word_from_proc;
  logic        sign_extend_from_proc;
  logic        stall_to_proc;
  logic [0:31] data_to_proc;
  logic        data_valid_to_proc;
  logic        error_to_proc;
  logic        req_to_mem;
  logic [0:31] addr_to_mem;
  logic [0:31] data_to_mem;
  logic [0:3]  byte_en_to_mem;
  logic        write_enable_to_mem;
  logic        ack_from_mem;
  logic [0:31] data_from_mem;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage_pipe dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .valid_from_proc        (valid_from_proc),
    .store_fp               (store_fp),
    .addr_from_proc         (addr_from_proc),
    .gp_data_from_proc      (gp_data_from_proc),
    .fp_data_from_proc      (fp_data_from_proc),
    .write_enable_from_proc (write_enable_from_proc),
    .byte_from_proc         (byte_from_proc),
    .half_word_from_proc    (half_word_from_proc),
    .sign_extend_from_proc  (sign_extend_from_proc),
    .stall_to_proc          (stall_to_proc),
    .data_to_proc           (data_to_proc),
    .data_valid_to_proc     (data_valid_to_proc),
    .error_to_proc          (error_to_proc),
    .req_to_mem             (req_to_mem),
    .addr_to_mem            (addr_to_mem),
    .data_to_mem            (data_to_mem),
    .byte_en_to_mem         (byte_en_to_mem),
    .write_enable_to_mem    (write_enable_to_mem),
    .ack_from_mem           (ack_from_mem),
    .data_from_mem          (data_from_mem)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access: drive at a falling edge, answer REQ with ack on REQ cycle
  // ack_at (0 = never), compare mem-side outputs every REQ cycle, and pop
  // the scoreboard on the completion pulse.
  task automatic run_access(
    input string       tag,
    input logic [31:0] addr, input logic we, bt, hw, sx, fp,
    input logic [31:0] gpd, fpd,
    input int          ack_at, input logic [31:0] rdata,
    input logic [31:0] exp_addr, exp_dmem, input logic [3:0] exp_be,
    input int          exp_stall, exp_reqn,
    input logic [31:0] exp_data, input logic exp_err);
    int   stall_n = 0;
    int   req_n   = 0;
    logic got     = 1'b0;
    exp_t e;
    addr_from_proc         = addr;
    write_enable_from_proc = we;
    byte_from_proc         = bt;
    half_word_from_proc    = hw;
    sign_extend_from_proc  = sx;
    store_fp               = fp;
    gp_data_from_proc      = gpd;
    fp_data_from_proc      = fpd;
    valid_from_proc        = 1'b1;
    sb.push_back('{data: exp_data, err: exp_err});
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (stall_to_proc) stall_n++;
      ack_from_mem = 1'b0;
      if (req_to_mem) begin
        req_n++;
        chk({tag, ".addr_to_mem"}, 64'(addr_to_mem), 64'(exp_addr));
        chk({tag, ".byte_en"}, 64'(byte_en_to_mem), 64'(exp_be));
        chk({tag, ".data_to_mem"}, 64'(data_to_mem), 64'(exp_dmem));
        chk({tag, ".we_to_mem"}, 64'(write_enable_to_mem), 64'(we));
        ack_from_mem  = (req_n == ack_at);
        data_from_mem = rdata;
      end
      if (data_valid_to_proc) begin
        got = 1'b1;
        valid_from_proc = 1'b0;
        if (sb.size() == 0) begin
          chk({tag, ".sb_empty"}, 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk({tag, ".data_to_proc"}, 64'(data_to_proc), 64'(e.data));
          chk({tag, ".error"}, 64'(error_to_proc), 64'(e.err));
        end
      end
      @(negedge clk);
    end
    chk({tag, ".completed"}, 64'(got), 64'(1));
    chk({tag, ".stall_cycles"}, 64'(stall_n), 64'(exp_stall));
    chk({tag, ".req_cycles"}, 64'(req_n), 64'(exp_reqn));
    #1;
    chk({tag, ".dv_one_cycle"}, 64'(data_valid_to_proc), 64'(0));
    chk({tag, ".data_held"}, 64'(data_to_proc), 64'(exp_data));
    valid_from_proc = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    valid_from_proc = 1'b0;
    store_fp = 1'b0;
    addr_from_proc = '0;
    gp_data_from_proc = '0;
    fp_data_from_proc = '0;
    write_enable_from_proc = 1'b0;
    byte_from_proc = 1'b0;
    half_word_from_proc = 1'b0;
    sign_extend_from_proc = 1'b0;
    ack_from_mem = 1'b0;
    data_from_mem = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.req", 64'(req_to_mem), 64'(0));
    chk("rst.dv", 64'(data_valid_to_proc), 64'(0));
    chk("rst.err", 64'(error_to_proc), 64'(0));
    chk("rst.data_to_proc", 64'(data_to_proc), 64'(0));
    chk("rst.addr_to_mem", 64'(addr_to_mem), 64'(0));
    chk("rst.data_to_mem", 64'(data_to_mem), 64'(0));
    chk("rst.byte_en", 64'(byte_en_to_mem), 64'(0));
    chk("rst.we", 64'(write_enable_to_mem), 64'(0));
    chk("rst.stall", 64'(stall_to_proc), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // tag, addr, we, byte, half, sext, fp, gp, fp, ack_at, rdata,
    // exp_addr, exp_dmem, exp_be, stall, reqs, exp_data, exp_err
    run_access("word_ld", 32'h100, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3, 32'hDEADBEEF,
               32'h100, 32'h0, 4'b1111, 4, 3, 32'hDEADBEEF, 0);
    run_access("sbyte_ld", 32'h103, 0, 1, 0, 1, 0, 32'h0, 32'h0, 1, 32'h123456F0,
               32'h100, 32'h0, 4'b0001, 2, 1, 32'hFFFFFFF0, 0);
    run_access("ubyte_ld", 32'h103, 0, 1, 0, 0, 0, 32'h0, 32'h0, 2, 32'h123456F0,
               32'h100, 32'h0, 4'b0001, 3, 2, 32'h000000F0, 0);
    run_access("fp_half_st", 32'h202, 1, 0, 1, 0, 1, 32'h11111111, 32'h0000ABCD, 1, 32'h0,
               32'h200, 32'hABCDABCD, 4'b0011, 2, 1, 32'h0, 0);
    run_access("shalf_ld", 32'h102, 0, 0, 1, 1, 0, 32'h0, 32'h0, 1, 32'h12348001,
               32'h100, 32'h0, 4'b0011, 2, 1, 32'hFFFF8001, 0);
    run_access("gp_byte_st", 32'h301, 1, 1, 0, 0, 0, 32'h000000A5, 32'hFFFFFFFF, 1, 32'h0,
               32'h300, 32'hA5A5A5A5, 4'b0100, 2, 1, 32'h0, 0);
    run_access("misal_half", 32'h101, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1, 32'h0,
               32'h0, 32'h0, 4'b0, 1, 0, 32'h0, 1);
    run_access("misal_word", 32'h102, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0,
               32'h0, 32'h0, 4'b0, 1, 0, 32'h0, 1);
    run_access("timeout", 32'h400, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
               32'h400, 32'h0, 4'b1111, 16, 15, 32'h0, 1);
    run_access("after_to", 32'h404, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hCAFEF00D,
               32'h404, 32'h0, 4'b1111, 2, 1, 32'hCAFEF00D, 0);

    // Reset during the second REQ cycle abandons the access.
    addr_from_proc = 32'h500;
    write_enable_from_proc = 1'b0;
    byte_from_proc = 1'b0;
    half_word_from_proc = 1'b0;
    valid_from_proc = 1'b1;
    ack_from_mem = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst.req1", 64'(req_to_mem), 64'(1));
    @(negedge clk);
    #1;
    chk("mid_rst.req2", 64'(req_to_mem), 64'(1));
    reset_n = 1'b0;
    valid_from_proc = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst.req_drop", 64'(req_to_mem), 64'(0));
    chk("mid_rst.dv", 64'(data_valid_to_proc), 64'(0));
    chk("mid_rst.stall", 64'(stall_to_proc), 64'(0));
    chk("mid_rst.data", 64'(data_to_proc), 64'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("mid_rst.no_dv", 64'(data_valid_to_proc), 64'(0));
    end
    @(negedge clk);
    run_access("after_rst", 32'h508, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2, 32'h01234567,
               32'h508, 32'h0, 4'b1111, 3, 2, 32'h01234567, 0);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
